// File: rtl/voice_mixer_seq_pkg.sv
// Shared packages for the voice mixer family.
//   CONFIG     : project-wide widths (audio sample width, percent/gain width).
//   PARAMETER  : runtime parameter bundle; .volume is the master volume.
//   MIXER_PKG  : mixer FSM state type and the sat_to_audio helper, intended to be
//                shared with future bus/effects mixers.
// No ports (package file).

package CONFIG;
  localparam int AUDIO_BIT_WIDTH = 16;
  localparam int PERCENT_WIDTH   = 7;
endpackage

package PARAMETER;
  typedef struct packed {
    logic [CONFIG::PERCENT_WIDTH-1:0] volume;
  } parameter_t;
endpackage

package MIXER_PKG;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    SCALE  = 2'd2,
    OUTPUT = 2'd3
  } mixer_state_e;

  // Widest value the helper accepts; callers sign-extend into this.
  localparam int SAT_IN_MAX = 64;

  localparam logic signed [SAT_IN_MAX-1:0] AUDIO_MAX =
    (64'sd1 <<< (CONFIG::AUDIO_BIT_WIDTH - 1)) - 64'sd1;
  localparam logic signed [SAT_IN_MAX-1:0] AUDIO_MIN =
    -(64'sd1 <<< (CONFIG::AUDIO_BIT_WIDTH - 1));

  typedef struct packed {
    logic                                     clip;
    logic signed [CONFIG::AUDIO_BIT_WIDTH-1:0] value;
  } sat_result_t;

  // Clamp a wide signed value to the project audio width and report clipping.
  function automatic sat_result_t sat_to_audio(input logic signed [SAT_IN_MAX-1:0] v);
    sat_result_t r;
    r.clip  = 1'b0;
    r.value = v[CONFIG::AUDIO_BIT_WIDTH-1:0];
    if (v > AUDIO_MAX) begin
      r.clip  = 1'b1;
      r.value = AUDIO_MAX[CONFIG::AUDIO_BIT_WIDTH-1:0];
    end else if (v < AUDIO_MIN) begin
      r.clip  = 1'b1;
      r.value = AUDIO_MIN[CONFIG::AUDIO_BIT_WIDTH-1:0];
    end
    return r;
  endfunction
endpackage

// File: rtl/voice_mixer_seq_saturate.sv
// mixer_saturate: combinational signed clamp from IN_W bits to OUT_W bits.
// Ports:
//   din  in  IN_W   signed value to clamp (IN_W > OUT_W)
//   dout out OUT_W  clamped value in [-2**(OUT_W-1), 2**(OUT_W-1)-1]
//   clip out 1      high when din was outside the output range

module mixer_saturate #(
  parameter int IN_W  = 35,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);

  // The value fits iff every bit from the output sign bit upward is identical.
  logic [IN_W-OUT_W:0] head;
  assign head = din[IN_W-1:OUT_W-1];

  always_comb begin
    clip = !((&head) || !(|head));
    dout = din[OUT_W-1:0];
    if (clip) begin
      dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/voice_mixer_seq.sv
// voice_mixer_seq: time-multiplexed voice mixer. On each accepted sample_tick it
// snapshots all inputs, accumulates one channel per clock through a single shared
// multiplier, scales by master volume with the same multiplier, saturates and
// presents one registered sample with a 1-cycle valid.
// Optional feature macro: MIXER_VOLUME_RAMP_EN -- master volume steps by 1 toward
// parameters.volume once per accepted tick instead of being captured directly.
// Ports:
//   clk, reset       single clock, synchronous active-high reset
//   sample_tick      start one mix (ignored and flagged while busy)
//   channel_audios   packed signed samples [CH-1:0][AUDIO_WIDTH-1:0]
//   channel_gains    packed unsigned gains [CH-1:0][GAIN_WIDTH-1:0]
//   channel_enables  per-channel enable
//   parameters       runtime bundle, .volume is master volume
//   audio_out        mixed saturated sample, held until next result
//   audio_valid      1-cycle pulse when audio_out updates
//   busy             high from accepted tick through the valid cycle
//   clipped          sticky: some result saturated since reset
//   tick_dropped     sticky: a tick arrived while busy

module voice_mixer_seq
  import MIXER_PKG::*;
#(
  parameter int CHANNEL_COUNT  = 4,
  parameter int AUDIO_WIDTH    = CONFIG::AUDIO_BIT_WIDTH,
  parameter int GAIN_WIDTH     = CONFIG::PERCENT_WIDTH,
  parameter int HEADROOM_SHIFT = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 sample_tick,
  input  logic [CHANNEL_COUNT*AUDIO_WIDTH-1:0] channel_audios,
  input  logic [CHANNEL_COUNT*GAIN_WIDTH-1:0]  channel_gains,
  input  logic [CHANNEL_COUNT-1:0]             channel_enables,
  input  PARAMETER::parameter_t                parameters,
  output logic [AUDIO_WIDTH-1:0]               audio_out,
  output logic                                 audio_valid,
  output logic                                 busy,
  output logic                                 clipped,
  output logic                                 tick_dropped
);

  localparam int PROD_W = AUDIO_WIDTH + GAIN_WIDTH + 1;
  // Sum of CHANNEL_COUNT products can never wrap at this width.
  localparam int ACC_W  = PROD_W + $clog2(CHANNEL_COUNT) + 1;
  localparam int MUL_W  = ACC_W + GAIN_WIDTH + 1;
  localparam int IDX_W  = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNEL_COUNT - 1);

  mixer_state_e state_reg;

  logic [CHANNEL_COUNT-1:0][AUDIO_WIDTH-1:0] audio_snap_reg;
  logic [CHANNEL_COUNT-1:0][GAIN_WIDTH-1:0]  gain_snap_reg;
  logic [CHANNEL_COUNT-1:0]                  en_snap_reg;
  logic [GAIN_WIDTH-1:0]                     master_snap_reg;
  logic signed [ACC_W-1:0]                   acc_reg;
  logic [IDX_W-1:0]                          idx_reg;

  logic                      tick_accept;
  logic [GAIN_WIDTH-1:0]     volume_in;
  logic [GAIN_WIDTH-1:0]     master_capture;

  assign tick_accept = sample_tick && (state_reg == IDLE);
  assign volume_in   = GAIN_WIDTH'(parameters.volume);

`ifdef MIXER_VOLUME_RAMP_EN
  // Master volume moves one step per accepted tick to avoid zipper noise;
  // the mix being started uses the already-stepped value.
  logic [GAIN_WIDTH-1:0] ramp_reg;
  logic [GAIN_WIDTH-1:0] ramp_next;

  always_comb begin
    ramp_next = ramp_reg;
    if (volume_in > ramp_reg) begin
      ramp_next = ramp_reg + GAIN_WIDTH'(1);
    end else if (volume_in < ramp_reg) begin
      ramp_next = ramp_reg - GAIN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ramp_reg <= '0;
    end else if (tick_accept) begin
      ramp_reg <= ramp_next;
    end
  end

  assign master_capture = ramp_next;
`else
  assign master_capture = volume_in;
`endif

  // Per-channel multiplier operands: sign-extended sample and zero-extended
  // gain, with disabled channels forced to a zero gain.
  logic signed [ACC_W-1:0]    chan_a [CHANNEL_COUNT];
  logic signed [GAIN_WIDTH:0] chan_b [CHANNEL_COUNT];

  generate
    for (genvar gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_chan
      assign chan_a[gi] = {{(ACC_W-AUDIO_WIDTH){audio_snap_reg[gi][AUDIO_WIDTH-1]}},
                           audio_snap_reg[gi]};
      assign chan_b[gi] = en_snap_reg[gi] ? {1'b0, gain_snap_reg[gi]} : '0;
    end
  endgenerate

  // Single shared multiplier: channel products in ACCUM, master scaling in SCALE.
  logic signed [ACC_W-1:0]    mul_a;
  logic signed [GAIN_WIDTH:0] mul_b;
  logic signed [MUL_W-1:0]    mul_p;
  logic signed [MUL_W-1:0]    scaled;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_reg)
      ACCUM: begin
        mul_a = chan_a[idx_reg];
        mul_b = chan_b[idx_reg];
      end
      SCALE: begin
        mul_a = acc_reg >>> GAIN_WIDTH;
        mul_b = {1'b0, master_snap_reg};
      end
      default: ;
    endcase
  end

  assign mul_p  = MUL_W'(mul_a) * MUL_W'(mul_b);
  assign scaled = mul_p >>> (GAIN_WIDTH + HEADROOM_SHIFT);

  logic signed [AUDIO_WIDTH-1:0] sat_value;
  logic                          sat_clip;

  mixer_saturate #(
    .IN_W  (MUL_W),
    .OUT_W (AUDIO_WIDTH)
  ) u_saturate (
    .din  (scaled),
    .dout (sat_value),
    .clip (sat_clip)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      audio_snap_reg  <= '0;
      gain_snap_reg   <= '0;
      en_snap_reg     <= '0;
      master_snap_reg <= '0;
      acc_reg         <= '0;
      idx_reg         <= '0;
      audio_out       <= '0;
      audio_valid     <= 1'b0;
      busy            <= 1'b0;
      clipped         <= 1'b0;
      tick_dropped    <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      // Any tick outside IDLE, including the OUTPUT cycle, is discarded.
      if (sample_tick && (state_reg != IDLE)) begin
        tick_dropped <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (sample_tick) begin
            audio_snap_reg  <= channel_audios;
            gain_snap_reg   <= channel_gains;
            en_snap_reg     <= channel_enables;
            master_snap_reg <= master_capture;
            acc_reg         <= '0;
            idx_reg         <= '0;
            busy            <= 1'b1;
            state_reg       <= ACCUM;
          end
        end
        ACCUM: begin
          // Products fit in PROD_W bits, so the low ACC_W bits carry the full value.
          acc_reg <= acc_reg + $signed(mul_p[ACC_W-1:0]);
          idx_reg <= idx_reg + IDX_W'(1);
          if (idx_reg == LAST_IDX) begin
            state_reg <= SCALE;
          end
        end
        SCALE: begin
          // Result is registered here so it is visible during the OUTPUT cycle.
          audio_out   <= sat_value;
          audio_valid <= 1'b1;
          if (sat_clip) begin
            clipped <= 1'b1;
          end
          state_reg <= OUTPUT;
        end
        OUTPUT: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer_seq.sv
// Self-checking bench for voice_mixer_seq (CHANNEL_COUNT=4, AUDIO_WIDTH=16,
// GAIN_WIDTH=7, HEADROOM_SHIFT=0). Build with MIXER_VOLUME_RAMP_EN defined to
// exercise the volume ramp sequence instead of the direct-volume vectors.

module tb_voice_mixer_seq;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  sample_tick;
  logic [63:0]           channel_audios;
  logic [27:0]           channel_gains;
  logic [3:0]            channel_enables;
  PARAMETER::parameter_t parameters;
  logic [15:0]           audio_out;
  logic                  audio_valid;
  logic                  busy;
  logic                  clipped;
  logic                  tick_dropped;

  int n_tests = 0;
  int n_fail  = 0;
  bit clip_m  = 1'b0;  // expected sticky clipped flag
  int master_m = 0;    // expected master volume used by the next accepted tick

  always #5 clk = ~clk;

  voice_mixer_seq #(
    .CHANNEL_COUNT  (4),
    .AUDIO_WIDTH    (16),
    .GAIN_WIDTH     (7),
    .HEADROOM_SHIFT (0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sample_tick     (sample_tick),
    .channel_audios  (channel_audios),
    .channel_gains   (channel_gains),
    .channel_enables (channel_enables),
    .parameters      (parameters),
    .audio_out       (audio_out),
    .audio_valid     (audio_valid),
    .busy            (busy),
    .clipped         (clipped),
    .tick_dropped    (tick_dropped)
  );

  typedef struct {
    string       name;
    logic [63:0] aud;
    logic [27:0] gn;
    logic [3:0]  en;
    logic [6:0]  vol;
    int          exp_out;
    bit          exp_clip;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference: gain g means g/128; floor shifts; clamp to 16-bit signed.
  function automatic int model_mix(input logic [63:0] aud, input logic [27:0] gn,
                                   input logic [3:0] en, input int master,
                                   output bit clip);
    longint s;
    longint t;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        s += longint'($signed(aud[16*i +: 16])) * longint'(gn[7*i +: 7]);
      end
    end
    t = ((s >>> 7) * longint'(master)) >>> 7;
    clip = 1'b0;
    if (t > 32767) begin
      clip = 1'b1;
      t = 32767;
    end else if (t < -32768) begin
      clip = 1'b1;
      t = -32768;
    end
    return int'(t);
  endfunction

  // Advance the expected master volume for one accepted tick.
  function automatic int step_master(input int vol);
`ifdef MIXER_VOLUME_RAMP_EN
    if (vol > master_m) master_m++;
    else if (vol < master_m) master_m--;
`else
    master_m = vol;
`endif
    return master_m;
  endfunction

  task automatic set_in(input logic [63:0] a, input logic [27:0] g,
                        input logic [3:0] e, input logic [6:0] v);
    channel_audios    = a;
    channel_gains     = g;
    channel_enables   = e;
    parameters.volume = v;
  endtask

  // One tick, wait (bounded) for the valid pulse, check timing and result.
  task automatic run_mix(input string name, input int exp_out);
    int lat;
    lat = 0;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check($sformatf("%s/busy_T1", name), longint'(busy), 1);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (audio_valid) begin
        lat = k;
        break;
      end
    end
    check($sformatf("%s/latency", name), lat, 6);
    if (lat != 0) begin
      check($sformatf("%s/audio_out", name), longint'($signed(audio_out)), exp_out);
      check($sformatf("%s/busy_valid", name), longint'(busy), 1);
      check($sformatf("%s/clipped", name), longint'(clipped), longint'(clip_m));
      $display("[TB] mix %s: audio_out=%0d expected=%0d latency=%0d", name,
               $signed(audio_out), exp_out, lat);
      @(negedge clk);
      check($sformatf("%s/valid_1cyc", name), longint'(audio_valid), 0);
      check($sformatf("%s/busy_drop", name), longint'(busy), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual stalled required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  exp_v;
    bit  mc;
    int  vcount;
    int  vcycle;
    int  vval;
    logic [63:0] a;
    logic [27:0] g;

    reset       = 1'b1;
    sample_tick = 1'b0;
    parameters  = '0;
    set_in('0, '0, '0, '0);

    vecs[0] = '{"single_ch0", 64'h0000_0000_0000_1000, {4{7'd127}}, 4'b0001, 7'd127, 4032, 1'b0};
    vecs[1] = '{"all_pos_clip", {4{16'd30000}}, {4{7'd127}}, 4'b1111, 7'd127, 32767, 1'b1};
    vecs[2] = '{"sticky_after_clip", 64'h0000_0000_0000_1000, {4{7'd127}}, 4'b0001, 7'd127, 4032, 1'b0};
    vecs[3] = '{"all_neg_clip", {4{16'h8AD0}}, {4{7'd127}}, 4'b1111, 7'd127, -32768, 1'b1};
    vecs[4] = '{"minus_one_floor", 64'h0000_0000_0000_FFFF, {4{7'd127}}, 4'b0001, 7'd127, -1, 1'b0};
    vecs[5] = '{"gains_zero", {4{16'd30000}}, 28'd0, 4'b1111, 7'd127, 0, 1'b0};
    vecs[6] = '{"all_disabled", {4{16'd30000}}, {4{7'd127}}, 4'b0000, 7'd127, 0, 1'b0};
    vecs[7] = '{"vol_zero", {4{16'd30000}}, {4{7'd127}}, 4'b1111, 7'd0, 0, 1'b0};
    vecs[8] = '{"two_ch_mixed", 64'h0000_0000_F448_03E8, {7'd0, 7'd0, 7'd32, 7'd64}, 4'b0011, 7'd100, -196, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst/audio_out", longint'(audio_out), 0);
    check("rst/audio_valid", longint'(audio_valid), 0);
    check("rst/busy", longint'(busy), 0);
    check("rst/clipped", longint'(clipped), 0);
    check("rst/tick_dropped", longint'(tick_dropped), 0);
    reset = 1'b0;

`ifndef MIXER_VOLUME_RAMP_EN
    // Directed vectors with hand-derived results
    for (int i = 0; i < 9; i++) begin
      set_in(vecs[i].aud, vecs[i].gn, vecs[i].en, vecs[i].vol);
      void'(step_master(int'(vecs[i].vol)));
      clip_m |= vecs[i].exp_clip;
      run_mix(vecs[i].name, vecs[i].exp_out);
    end

    // Tick at T, inputs change at T+1, second tick at T+3
    check("drop/before", longint'(tick_dropped), 0);
    set_in(64'h0000_0000_0000_1000, {4{7'd127}}, 4'b0001, 7'd127);
    void'(step_master(127));
    vcount = 0;
    vcycle = -1;
    vval   = 0;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      if (audio_valid) begin
        vcount++;
        vcycle = k;
        vval   = $signed(audio_out);
      end
      sample_tick = (k == 0) || (k == 3);
      if (k == 1) set_in({4{16'h7000}}, {4{7'd127}}, 4'b1111, 7'd50);
    end
    sample_tick = 1'b0;
    check("drop/valid_count", vcount, 1);
    check("drop/valid_cycle", vcycle, 6);
    check("drop/audio_out", vval, 4032);
    check("drop/tick_dropped", longint'(tick_dropped), 1);
    $display("[TB] mix drop_seq: valids=%0d cycle=%0d audio_out=%0d", vcount, vcycle, vval);
`else
    // Volume ramp: master steps 1,2,3,4,5,5 toward volume 5
    begin
      int ramp_exp[6];
      ramp_exp = '{31, 63, 95, 127, 158, 158};
      set_in(64'h0000_0000_0000_1000, {4{7'd127}}, 4'b0001, 7'd5);
      for (int i = 0; i < 6; i++) begin
        void'(step_master(5));
        run_mix($sformatf("ramp%0d", i), ramp_exp[i]);
      end
    end
`endif

    // Randomised mixes against the reference model
    for (int r = 0; r < 30; r++) begin
      a = {$urandom, $urandom};
      g = 28'($urandom);
      if ((r % 5) == 0) begin
        a = (r % 10 == 0) ? {4{16'h7F00}} : {4{16'h8100}};
        g = {4{7'd127}};
      end
      set_in(a, g, 4'($urandom), 7'($urandom));
      exp_v = model_mix(channel_audios, channel_gains, channel_enables,
                        step_master(int'(parameters.volume)), mc);
      clip_m |= mc;
      run_mix($sformatf("rand%0d", r), exp_v);
    end

    // Reset held 3 cycles in the middle of ACCUM abandons the mix
    set_in(64'h0000_0000_0000_1000, {4{7'd127}}, 4'b0001, 7'd127);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("midrst/audio_out", longint'(audio_out), 0);
    check("midrst/audio_valid", longint'(audio_valid), 0);
    check("midrst/busy", longint'(busy), 0);
    check("midrst/clipped", longint'(clipped), 0);
    check("midrst/tick_dropped", longint'(tick_dropped), 0);
    master_m = 0;
    clip_m   = 1'b0;
    vcount   = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (audio_valid) vcount++;
    end
    check("midrst/no_valid", vcount, 0);
    $display("[TB] mix midreset: valids_after=%0d", vcount);

    // First mix after reset
    exp_v = model_mix(channel_audios, channel_gains, channel_enables, step_master(127), mc);
    clip_m |= mc;
    run_mix("post_reset", exp_v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
